// File: rtl/axi_pack_conv_ax_nd_affine.sv
// ---------------------------------------------------------------------------
// axi_pack_conv_ax_nd_affine
//
// Purpose: walks an N-dimensional affine element pattern (base address plus
// per-dimension signed byte strides and bounds) and emits AXI AX requests.
// When dimension 0 is contiguous (stride == element size) elements are merged
// into INCR bursts that never cross a 4 KiB page or exceed MaxBurstBeats;
// otherwise every element becomes a single-beat burst. Each issued burst also
// pushes a metadata entry (byte offset, length, last flag) for a downstream
// packer.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              abort the request currently being issued
//   req_*                request handshake and descriptor fields
//   ax_*                 AXI AX channel (address, len, size, id, burst)
//   meta_push_o/full_i   metadata queue push / backpressure
//   meta_offset_o        low address bits of the burst within a data word
//   meta_len_o           copy of ax_len_o
//   meta_last_o          burst completes the request
//   err_o                one-cycle pulse for a request with an illegal size
// ---------------------------------------------------------------------------
module axi_pack_conv_ax_nd_affine #(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned IdWidth       = 4,
  parameter int unsigned NumDims       = 4,
  parameter int unsigned StrideWidth   = 20,
  parameter int unsigned BoundWidth    = 16,
  parameter int unsigned MaxBurstBeats = 256,
  localparam int unsigned OffLog       = $clog2(DataWidth / 8),
  localparam int unsigned OffWidth     = (OffLog > 0) ? OffLog : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [AddrWidth-1:0]           req_addr_i,
  input  logic [2:0]                     req_size_i,
  input  logic [IdWidth-1:0]             req_id_i,
  input  logic [NumDims*BoundWidth-1:0]  req_bound_i,
  input  logic [NumDims*StrideWidth-1:0] req_stride_i,
  output logic                           ax_valid_o,
  input  logic                           ax_ready_i,
  output logic [AddrWidth-1:0]           ax_addr_o,
  output logic [7:0]                     ax_len_o,
  output logic [2:0]                     ax_size_o,
  output logic [IdWidth-1:0]             ax_id_o,
  output logic [1:0]                     ax_burst_o,
  output logic                           meta_push_o,
  input  logic                           meta_full_i,
  output logic [OffWidth-1:0]            meta_offset_o,
  output logic [7:0]                     meta_len_o,
  output logic                           meta_last_o,
  output logic                           err_o
);

  localparam int unsigned CntWidth = (BoundWidth + 1 > 13) ? BoundWidth + 1 : 13;

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                 state_q;
  logic [2:0]             size_q;
  logic [IdWidth-1:0]     id_q;
  logic                   err_q;
  logic [BoundWidth-1:0]  bound_q  [NumDims];
  logic [StrideWidth-1:0] stride_q [NumDims];
  logic [BoundWidth-1:0]  cnt_q    [NumDims];
  logic [BoundWidth-1:0]  cnt_d    [NumDims];
  // base_q[d]: address of the element with all dims below d at zero
  logic [AddrWidth-1:0]   base_q   [NumDims];
  logic [AddrWidth-1:0]   base_d   [NumDims];
  logic [AddrWidth-1:0]   ptr_q, ptr_d;

  logic                   contiguous, wrap0, lastBurst, carry, fire;
  logic [CntWidth-1:0]    remaining, pageRem, cand;
  logic [12:0]            pageRaw;
  logic [8:0]             beats;
  logic [AddrWidth-1:0]   step, newBase;

  function automatic logic [AddrWidth-1:0] sext(input logic [StrideWidth-1:0] s);
    return {{(AddrWidth - StrideWidth){s[StrideWidth-1]}}, s};
  endfunction

  // Burst length: limited by the rest of the dim-0 row, the beat cap and the
  // 4 KiB page. A misaligned element can make the page term zero; clamp to 1.
  always_comb begin
    contiguous = (stride_q[0] == (StrideWidth'(1) << size_q));
    remaining  = CntWidth'(bound_q[0]) - CntWidth'(cnt_q[0]) + CntWidth'(1);
    pageRaw    = (13'd4096 - {1'b0, ptr_q[11:0]}) >> size_q;
    pageRem    = CntWidth'(pageRaw);
    cand       = remaining;
    if (cand > CntWidth'(MaxBurstBeats)) cand = CntWidth'(MaxBurstBeats);
    if (cand > pageRem) cand = pageRem;
    if (cand == '0 || !contiguous) cand = CntWidth'(1);
    beats = 9'(cand);
    wrap0 = (cand == remaining);
  end

  always_comb begin
    lastBurst = wrap0;
    for (int d = 1; d < NumDims; d++) begin
      if (cnt_q[d] != bound_q[d]) lastBurst = 1'b0;
    end
  end

  // Next position after a fire. Dim 0 moves by the burst; when it wraps, the
  // lowest non-wrapping dim steps its base and every lower dim restarts there.
  always_comb begin
    cnt_d   = cnt_q;
    base_d  = base_q;
    ptr_d   = ptr_q;
    carry   = 1'b0;
    newBase = '0;
    step    = contiguous ? (AddrWidth'(beats) << size_q) : sext(stride_q[0]);
    if (!wrap0) begin
      cnt_d[0] = cnt_q[0] + BoundWidth'(beats);
      ptr_d    = ptr_q + step;
    end else begin
      cnt_d[0] = '0;
      carry    = 1'b1;
      for (int d = 1; d < NumDims; d++) begin
        if (carry) begin
          if (cnt_q[d] == bound_q[d]) begin
            cnt_d[d] = '0;
          end else begin
            cnt_d[d] = cnt_q[d] + BoundWidth'(1);
            newBase  = base_q[d] + sext(stride_q[d]);
            for (int j = 0; j < NumDims; j++) begin
              if (j <= d) base_d[j] = newBase;
            end
            ptr_d = newBase;
            carry = 1'b0;
          end
        end
      end
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign ax_valid_o    = (state_q == ISSUE) && !meta_full_i;
  assign fire          = ax_valid_o && ax_ready_i;
  assign ax_addr_o     = ptr_q;
  assign ax_len_o      = 8'(beats - 9'd1);
  assign ax_size_o     = size_q;
  assign ax_id_o       = id_q;
  assign ax_burst_o    = 2'b01;
  assign meta_push_o   = fire;
  assign meta_offset_o = ptr_q[OffWidth-1:0];
  assign meta_len_o    = ax_len_o;
  assign meta_last_o   = lastBurst;
  assign err_o         = err_q;

  // Request FSM; a flush wins over staying in ISSUE but a same-cycle fire
  // still advances the counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      size_q  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      for (int d = 0; d < NumDims; d++) begin
        bound_q[d]  <= '0;
        stride_q[d] <= '0;
        cnt_q[d]    <= '0;
        base_q[d]   <= '0;
      end
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            size_q <= req_size_i;
            id_q   <= req_id_i;
            ptr_q  <= req_addr_i;
            for (int d = 0; d < NumDims; d++) begin
              bound_q[d]  <= req_bound_i[d*BoundWidth +: BoundWidth];
              stride_q[d] <= req_stride_i[d*StrideWidth +: StrideWidth];
              cnt_q[d]    <= '0;
              base_q[d]   <= req_addr_i;
            end
            if (req_size_i > 3'(OffLog)) err_q <= 1'b1;
            else                         state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (fire) begin
            cnt_q  <= cnt_d;
            base_q <= base_d;
            ptr_q  <= ptr_d;
            if (lastBurst) state_q <= IDLE;
          end
          if (flush_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_pack_conv_ax_nd_affine.sv
// ---------------------------------------------------------------------------
// tb_axi_pack_conv_ax_nd_affine
//
// Directed bench for axi_pack_conv_ax_nd_affine at default parameters.
// Expected burst addresses/lengths are hand-computed constants per step.
// ---------------------------------------------------------------------------
module tb_axi_pack_conv_ax_nd_affine;

  logic        clk = 1'b0;
  logic        rstN;
  logic        flush;
  logic        reqValid;
  logic        reqReady;
  logic [47:0] reqAddr;
  logic [2:0]  reqSize;
  logic [3:0]  reqId;
  logic [63:0] reqBound;
  logic [79:0] reqStride;
  logic        axValid;
  logic        axReady;
  logic [47:0] axAddr;
  logic [7:0]  axLen;
  logic [2:0]  axSize;
  logic [3:0]  axId;
  logic [1:0]  axBurst;
  logic        metaPush;
  logic        metaFull;
  logic [2:0]  metaOffset;
  logic [7:0]  metaLen;
  logic        metaLast;
  logic        err;

  int testsRun    = 0;
  int testsFailed = 0;
  int pushCount   = 0;
  int pushMark;

  axi_pack_conv_ax_nd_affine dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .flush_i       (flush),
    .req_valid_i   (reqValid),
    .req_ready_o   (reqReady),
    .req_addr_i    (reqAddr),
    .req_size_i    (reqSize),
    .req_id_i      (reqId),
    .req_bound_i   (reqBound),
    .req_stride_i  (reqStride),
    .ax_valid_o    (axValid),
    .ax_ready_i    (axReady),
    .ax_addr_o     (axAddr),
    .ax_len_o      (axLen),
    .ax_size_o     (axSize),
    .ax_id_o       (axId),
    .ax_burst_o    (axBurst),
    .meta_push_o   (metaPush),
    .meta_full_i   (metaFull),
    .meta_offset_o (metaOffset),
    .meta_len_o    (metaLen),
    .meta_last_o   (metaLast),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  // Independent tally of metadata pushes seen at clock edges
  always @(posedge clk) begin
    if (metaPush === 1'b1) pushCount <= pushCount + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single accepting cycle (dims 2 and 3 trivial)
  task automatic applyStimulus(input logic [47:0] addr, input logic [2:0] size,
                               input logic [15:0] b0, input logic [15:0] b1,
                               input logic [19:0] s0, input logic [19:0] s1);
    reqAddr   = addr;
    reqSize   = size;
    reqId     = 4'hA;
    reqBound  = {16'd0, 16'd0, b1, b0};
    reqStride = {20'd0, 20'd0, s1, s0};
    reqValid  = 1'b1;
    tick();
    reqValid  = 1'b0;
  endtask

  // Check the burst on offer with ax_ready high, then let it fire
  task automatic expectAx(input string tag, input logic [47:0] addr, input logic [7:0] len, input logic last);
    checkOutput({tag, ".valid"}, 64'(axValid), 64'd1);
    checkOutput({tag, ".addr"}, 64'(axAddr), 64'(addr));
    checkOutput({tag, ".len"}, 64'(axLen), 64'(len));
    checkOutput({tag, ".metaLen"}, 64'(metaLen), 64'(len));
    checkOutput({tag, ".last"}, 64'(metaLast), 64'(last));
    checkOutput({tag, ".push"}, 64'(metaPush), 64'd1);
    checkOutput({tag, ".id"}, 64'(axId), 64'hA);
    checkOutput({tag, ".burst"}, 64'(axBurst), 64'd1);
    tick();
  endtask

  initial begin
    rstN      = 1'b0;
    flush     = 1'b0;
    reqValid  = 1'b0;
    reqAddr   = '0;
    reqSize   = '0;
    reqId     = '0;
    reqBound  = '0;
    reqStride = '0;
    axReady   = 1'b0;
    metaFull  = 1'b0;

    // Reset values
    tick();
    tick();
    checkOutput("rst.ready", 64'(reqReady), 64'd1);
    checkOutput("rst.valid", 64'(axValid), 64'd0);
    checkOutput("rst.push", 64'(metaPush), 64'd0);
    checkOutput("rst.err", 64'(err), 64'd0);
    rstN = 1'b1;
    tick();

    // Single contiguous burst
    axReady = 1'b1;
    applyStimulus(48'h1000, 3'd2, 16'd7, 16'd0, 20'd4, 20'd0);
    checkOutput("one.size", 64'(axSize), 64'd2);
    checkOutput("one.offset", 64'(metaOffset), 64'd0);
    expectAx("one", 48'h1000, 8'd7, 1'b1);
    checkOutput("one.idle", 64'(reqReady), 64'd1);
    checkOutput("one.noax", 64'(axValid), 64'd0);

    // 4 KiB page split
    applyStimulus(48'h0FF8, 3'd3, 16'd3, 16'd0, 20'd8, 20'd0);
    expectAx("page0", 48'h0FF8, 8'd0, 1'b0);
    expectAx("page1", 48'h1000, 8'd2, 1'b1);

    // Two-dimensional singles with a negative outer stride
    applyStimulus(48'h100, 3'd2, 16'd1, 16'd1, 20'd16, -20'sd64);
    expectAx("nd0", 48'h100, 8'd0, 1'b0);
    expectAx("nd1", 48'h110, 8'd0, 1'b0);
    expectAx("nd2", 48'h0C0, 8'd0, 1'b0);
    expectAx("nd3", 48'h0D0, 8'd0, 1'b1);
    checkOutput("nd.idle", 64'(reqReady), 64'd1);

    // Beat cap: 300 byte elements -> 256 + 44
    applyStimulus(48'h0, 3'd0, 16'd299, 16'd0, 20'd1, 20'd0);
    expectAx("cap0", 48'h0, 8'd255, 1'b0);
    expectAx("cap1", 48'h100, 8'd43, 1'b1);

    // Address wrap-around at the top of the address space
    applyStimulus(48'hFFFF_FFFF_FFFC, 3'd2, 16'd1, 16'd0, 20'd4, 20'd0);
    checkOutput("wrap.offset", 64'(metaOffset), 64'd4);
    expectAx("wrap0", 48'hFFFF_FFFF_FFFC, 8'd0, 1'b0);
    expectAx("wrap1", 48'h0, 8'd0, 1'b1);

    // Stall with toggling metadata-full: outputs hold, no pushes
    axReady  = 1'b0;
    pushMark = pushCount;
    applyStimulus(48'h100, 3'd2, 16'd1, 16'd1, 20'd16, -20'sd64);
    for (int i = 0; i < 5; i++) begin
      metaFull = i[0];
      #1;
      checkOutput("stall.valid", 64'(axValid), 64'(!i[0]));
      checkOutput("stall.addr", 64'(axAddr), 64'h100);
      checkOutput("stall.len", 64'(axLen), 64'd0);
      checkOutput("stall.push", 64'(metaPush), 64'd0);
      tick();
    end
    metaFull = 1'b0;
    axReady  = 1'b1;
    #1;
    expectAx("stall0", 48'h100, 8'd0, 1'b0);
    expectAx("stall1", 48'h110, 8'd0, 1'b0);
    expectAx("stall2", 48'h0C0, 8'd0, 1'b0);
    expectAx("stall3", 48'h0D0, 8'd0, 1'b1);
    checkOutput("stall.pushes", 64'(pushCount - pushMark), 64'd4);

    // Flush on the second fire of a four-burst request
    pushMark = pushCount;
    applyStimulus(48'h100, 3'd2, 16'd1, 16'd1, 20'd16, -20'sd64);
    expectAx("flush0", 48'h100, 8'd0, 1'b0);
    flush = 1'b1;
    #1;
    checkOutput("flush1.addr", 64'(axAddr), 64'h110);
    checkOutput("flush1.push", 64'(metaPush), 64'd1);
    tick();
    flush = 1'b0;
    checkOutput("flush.idle", 64'(reqReady), 64'd1);
    checkOutput("flush.noax", 64'(axValid), 64'd0);
    tick();
    tick();
    checkOutput("flush.pushes", 64'(pushCount - pushMark), 64'd2);

    // Illegal element size
    applyStimulus(48'h2000, 3'd7, 16'd3, 16'd0, 20'd8, 20'd0);
    checkOutput("err.pulse", 64'(err), 64'd1);
    checkOutput("err.noax", 64'(axValid), 64'd0);
    checkOutput("err.ready", 64'(reqReady), 64'd1);
    tick();
    checkOutput("err.clear", 64'(err), 64'd0);
    checkOutput("err.stillnoax", 64'(axValid), 64'd0);

    // Reset in the middle of issuing abandons the request
    axReady  = 1'b0;
    pushMark = pushCount;
    applyStimulus(48'h1000, 3'd2, 16'd7, 16'd0, 20'd4, 20'd0);
    checkOutput("midrst.pre", 64'(axValid), 64'd1);
    rstN = 1'b0;
    #1;
    checkOutput("midrst.valid", 64'(axValid), 64'd0);
    checkOutput("midrst.ready", 64'(reqReady), 64'd1);
    tick();
    rstN    = 1'b1;
    axReady = 1'b1;
    tick();
    tick();
    checkOutput("midrst.after", 64'(axValid), 64'd0);
    checkOutput("midrst.pushes", 64'(pushCount - pushMark), 64'd0);

    // Flush while idle has no effect on a new request
    flush = 1'b1;
    applyStimulus(48'h1000, 3'd2, 16'd7, 16'd0, 20'd4, 20'd0);
    flush = 1'b0;
    expectAx("idleflush", 48'h1000, 8'd7, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/axi_pack_conv_ax_nd_affine.md
AXI_PACK_CONV_AX_ND_AFFINE -- requirements
Module: axi_pack_conv_ax_nd_affine

Interface
REQ-001 SHALL have parameter AddrWidth, default 48, address width.
REQ-002 SHALL have parameter DataWidth, default 64, output AXI data width in bits (power of two, >=8).
REQ-003 SHALL have parameter IdWidth, default 4, AXI ID width.
REQ-004 SHALL have parameter NumDims, default 4, loop dimensions (1..4); dim 0 is innermost.
REQ-005 SHALL have parameter StrideWidth, default 20, signed per-dimension byte stride width.
REQ-006 SHALL have parameter BoundWidth, default 16, per-dimension bound width (bound = count-1).
REQ-007 SHALL have parameter MaxBurstBeats, default 256, maximum beats per AX (1..256).
REQ-008 One clock; reset is asynchronous and active-low.
REQ-009 Ports (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- flush_i  in  1  abort current request
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_addr_i  in  AddrWidth  base byte address
- req_size_i  in  3  element size, log2 bytes
- req_id_i  in  IdWidth  AXI ID
- req_bound_i  in  NumDims*BoundWidth  per-dimension bounds
- req_stride_i  in  NumDims*StrideWidth  signed per-dimension byte strides
- ax_valid_o  out  1  AX valid
- ax_ready_i  in  1  AX ready
- ax_addr_o  out  AddrWidth  burst address
- ax_len_o  out  8  beats-1
- ax_size_o  out  3  beat size
- ax_id_o  out  IdWidth  ID
- ax_burst_o  out  2  always INCR
- meta_push_o  out  1  metadata push
- meta_full_i  in  1  metadata queue full
- meta_offset_o  out  log2(DataWidth/8)  ax_addr_o low bits
- meta_len_o  out  8  copy of ax_len_o
- meta_last_o  out  1  final burst of request
- err_o  out  1  one-cycle pulse, illegal request

Function
REQ-010 FSM states IDLE and ISSUE; req_ready_o = 1 only in IDLE.
REQ-011 req_valid_i & req_ready_o latches all req_* fields; next cycle state = ISSUE, ax_valid_o = 1 (1-cycle latency).
REQ-012 req_size_i > log2(DataWidth/8): accept, stay IDLE, no AX, err_o = 1 next cycle.
REQ-013 Element (c0..cN-1) address = base + sum(cd*sign_ext(stride_d)), modulo 2^AddrWidth; wrap-around is legal and not flagged.
REQ-014 Iteration order: dim 0 fastest; dim d wraps to 0 after bound_d and carries into dim d+1.
REQ-015 Contiguous mode (stride_0 == 1<<size): beats = min(bound_0-c0+1, MaxBurstBeats, (4096-addr[11:0])>>size); else beats = 1.
REQ-016 ax_len_o = beats-1, ax_size_o = latched size, ax_addr_o = current element address, ax_burst_o = INCR, ax_id_o = latched ID.
REQ-017 ax_valid_o = ISSUE & ~meta_full_i; fire = ax_valid_o & ax_ready_i; meta_push_o = fire.
REQ-018 AX and meta outputs stable while ax_valid_o & ~ax_ready_i.
REQ-019 On fire, c0 advances by beats; carries propagate combinationally within the same cycle; next AX address ready next cycle (no bubble).
REQ-020 meta_last_o = 1 iff this burst reaches all cd == bound_d; its fire returns FSM to IDLE.
REQ-021 Address kept incrementally (per-dimension start-address registers plus running pointer); no multipliers.
REQ-022 flush_i in ISSUE: IDLE next cycle, no further AX; a fire in the same cycle still counts; flush_i in IDLE ignored.
REQ-023 meta_full_i rising while ax_valid_o=1 and ax_ready_i=0 drops ax_valid_o (AXI-exempt by queue contract).

Reset
REQ-024 While rst_ni=0: state IDLE, counters and address registers 0, ax_valid_o=0, meta_push_o=0, err_o=0, req_ready_o=1.
REQ-025 Reset mid-ISSUE abandons the request; no AX after deassertion until a new request.

Verification
REQ-026 addr 0x1000, size 2, NumDims 1, bound0 7, stride0 4 -> one AX addr 0x1000, len 7, meta_last 1.
REQ-027 addr 0x0FF8, size 3, bound0 3, stride0 8 -> AX 0x0FF8 len 0, then 0x1000 len 2 (4KB split).
REQ-028 addr 0x100, size 2, bound0 1, stride0 16, bound1 1, stride1 -64 -> singles at 0x100, 0x110, 0x0C0, 0x0D0; last only on 4th.
REQ-029 ax_ready_i low 5 cycles, meta_full_i toggling -> outputs stable, exactly one push per fire.
REQ-030 flush_i on 2nd fire of 4-burst request -> 2 AX total, IDLE next cycle; req_size_i 7 at DataWidth 64 -> err_o pulse, no AX.
